pwm_multichannel: RTL and testbench
===================================

# pwm_multichannel

Multi-channel PWM generator with a shared period counter. Per-channel duty, enable and polarity are double-buffered: they are staged on an update strobe and applied atomically at the next period boundary. It adds edge- and center-aligned counting modes and optional per-channel phase offsets. It sits between a register/control front end and pad drivers, replacing single-channel PWM instances when several outputs must stay phase-coherent.

## Interface
- WIDTH, 8: counter, period, duty and phase width.
- NUM_CHANNELS, 4: number of PWM outputs.
- DEFAULT_PERIOD, 2**WIDTH-1: active period after reset.
- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- update_parameters  in  1  one-cycle strobe; captures all parameter inputs into staging.
- pwm_period  in  WIDTH  period in counter steps.
- align_mode  in  1  pwm_pkg::align_mode_t; 0 EDGE, 1 CENTER.
- pwm_duty_cycle  in  NUM_CHANNELS×WIDTH  per-channel duty, packed.
- channel_enable  in  NUM_CHANNELS  per-channel enable.
- channel_invert  in  NUM_CHANNELS  per-channel output polarity.
- pwm_phase  in  NUM_CHANNELS×WIDTH  per-channel phase offset; present only with PWM_PHASE_OFFSET_EN.
- pwm  out  NUM_CHANNELS  PWM outputs, registered.
- period_start  out  1  one-cycle pulse on the first cycle of each period.
- update_pending  out  1  staged parameters are not yet applied.

## Operation
- Reset (async assert, sync release):
  - All outputs 0.
  - Active period = DEFAULT_PERIOD, mode EDGE, duty 0, enable 0, invert 0, phase 0.
  - Counter 0, direction up, staging cleared.
- EDGE mode, period P:
  - Counter runs 0..P-1, then wraps to 0.
  - Period length is P cycles.
  - Raw output = (cnt_eff < duty), where cnt_eff = cnt, or (cnt+phase) mod P when phase is enabled.
- CENTER mode, period P:
  - Counter runs up 0..P-1, then down P-1..0.
  - Period length is 2P cycles. period_start fires on the first up-count 0.
  - Raw output = (cnt < duty), giving 2·duty high cycles per period, symmetric about the turnaround.
  - Phase is ignored.
- Duty limits: duty 0 gives constant low; duty ≥ P gives constant high.
- Period 0 behaves as period 1 (period_start every cycle in EDGE, every 2 cycles in CENTER).
- Phase value ≥ P is treated as 0. The (cnt+phase) sum is computed at WIDTH+1 bits, with P subtracted when the sum is ≥ P.
- Channel output: pwm[i] = enable[i] ? raw[i] ^ invert[i] : invert[i]. A disabled channel idles at its inactive level.
- Double buffering:
  - update_parameters copies all inputs to staging and sets update_pending.
  - Staging moves to active on the cycle the counter begins a new period, and update_pending clears on that same edge.
  - A second strobe while pending overwrites staging; the latest values win.
  - A strobe in the final cycle of a period applies at the immediately following period_start.
  - A mode or period change resets the counter to 0 and direction to up at the boundary.
- Reset mid-period discards staged and active values and returns to the reset defaults.

## Timing
- Counter, compare and output are registered and mutually aligned. period_start and pwm[i] rise on the same cycle for duty > 0.
- Latency from update_parameters to the new values at the outputs equals the remaining cycles of the current period plus 0.
- update_pending is high from the cycle after the strobe through the last cycle of the period.
- Outputs are glitch-free: each is a single flop per channel.

## Configuration
- PWM_PHASE_OFFSET_EN defined:
  - The pwm_phase port, staging and active phase registers exist.
  - EDGE-mode compare uses the rotated count.
- PWM_PHASE_OFFSET_EN undefined:
  - The port is absent and cnt_eff = cnt.
  - All channels are edge-aligned to period_start.

## Structure
- pwm_pkg holds:
  - align_mode_t enum (ALIGN_EDGE, ALIGN_CENTER).
  - A channel_cfg_t struct {duty, enable, invert, phase}.
- One sub-module, pwm_compare_channel. It takes the counter, active period and channel config, and produces the registered pwm[i]. It is instantiated NUM_CHANNELS times in a generate loop.
- The top level owns the counter, direction flag, staging/active registers and update_pending.

## Test plan
- Reset defaults: release reset_n with no update → all pwm 0; period_start every 255 cycles; update_pending 0.
- EDGE sweep: P=63, one channel enabled, duty swept 1..63, 4 periods per duty value. Required: high count = 4·duty and exactly 4 period_start pulses per duty; duty 0 gives all low; duty 70 gives all high.
- CENTER mode: P=10, duty 3 → 6 high cycles per 20-cycle period, high on cnt 0..2 on both slopes; period_start every 20 cycles.
- Update boundary:
  - Strobe at a random cycle mid-period → old duty holds until the next period_start; update_pending is high in between.
  - Strobe in the last cycle → new duty applies on the very next period.
  - Two strobes in one period → only the second takes effect.
- Enable/invert: channel with invert=1 and enable=0 → constant 1; enable=1, duty 4, P=16 → 4 cycles low and 12 high per period.
- Phase, with macro defined: P=16, duty 8, phase 4 on channel 1 and 0 on channel 0 → channel 1 waveform leads channel 0 by 4 cycles; phase 20 → identical to channel 0.
- Reset mid-operation: assert reset_n low mid-period with an update pending → outputs 0 immediately, pending cleared, defaults active after release.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types for the multi-channel PWM generator.
// CFG_WIDTH is the storage width of the per-channel config fields. Narrower
// counters are zero-extended into it, so WIDTH must not exceed CFG_WIDTH.
package pwm_pkg;

    localparam int CFG_WIDTH = 16;

    typedef enum logic {
        ALIGN_EDGE   = 1'b0,
        ALIGN_CENTER = 1'b1
    } align_mode_t;

    typedef struct packed {
        logic [CFG_WIDTH-1:0] duty;
        logic                 enable;
        logic                 invert;
        logic [CFG_WIDTH-1:0] phase;
    } channel_cfg_t;

endpackage

// File: rtl/pwm_compare_channel.sv
// pwm_compare_channel: one PWM output. It compares the (optionally phase
// rotated) count against the duty and registers the polarity-corrected result.
// It is driven with next-cycle count and config, so the registered output lines
// up with the top-level counter and period_start.
// The phase field is zero unless PWM_PHASE_OFFSET_EN is defined at the top.
module pwm_compare_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] period,
    input  align_mode_t      align_mode,
    input  channel_cfg_t     cfg,
    output logic             pwm
);

    localparam int SUM_W = CFG_WIDTH + 1;

    logic [SUM_W-1:0] cnt_ext;
    logic [SUM_W-1:0] per_ext;
    logic [SUM_W-1:0] phase_ext;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] cnt_eff;
    logic             raw;
    logic             pwm_nxt;

    // Rotate the count by the phase in EDGE mode (out-of-range phase acts as 0),
    // then compare it against the duty and apply enable/invert.
    always_comb begin
        cnt_ext   = SUM_W'(cnt);
        per_ext   = SUM_W'(period);
        phase_ext = {1'b0, cfg.phase};
        if (phase_ext >= per_ext) begin
            phase_ext = '0;
        end
        sum = cnt_ext + phase_ext;
        if (sum >= per_ext) begin
            sum = sum - per_ext;
        end
        cnt_eff = (align_mode == ALIGN_EDGE) ? sum : cnt_ext;
        raw     = (cnt_eff < {1'b0, cfg.duty});
        pwm_nxt = cfg.enable ? (raw ^ cfg.invert) : cfg.invert;
    end

    // One flop per output keeps the pad drive glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm <= 1'b0;
        end else begin
            pwm <= pwm_nxt;
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: shared-counter PWM generator with double-buffered
// per-channel settings and edge- or center-aligned counting.
// Optional feature macro: PWM_PHASE_OFFSET_EN adds the pwm_phase port and
// per-channel phase rotation in EDGE mode.
// Settings staged by update_parameters are loaded on the edge that starts a
// new period. A strobe on that same edge is loaded straight from the inputs.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter int               NUM_CHANNELS   = 4,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = {WIDTH{1'b1}}
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          update_parameters,
    input  logic [WIDTH-1:0]              pwm_period,
    input  align_mode_t                   align_mode,
    input  logic [NUM_CHANNELS*WIDTH-1:0] pwm_duty_cycle,
    input  logic [NUM_CHANNELS-1:0]       channel_enable,
    input  logic [NUM_CHANNELS-1:0]       channel_invert,
`ifdef PWM_PHASE_OFFSET_EN
    input  logic [NUM_CHANNELS*WIDTH-1:0] pwm_phase,
`endif
    output logic [NUM_CHANNELS-1:0]       pwm,
    output logic                          period_start,
    output logic                          update_pending
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             cnt_down;
    logic             cnt_down_nxt;
    logic             boundary;
    logic             load;

    logic [WIDTH-1:0] act_period;
    logic [WIDTH-1:0] stg_period;
    logic [WIDTH-1:0] src_period;
    logic [WIDTH-1:0] nxt_period;
    logic [WIDTH-1:0] period_eff;
    logic [WIDTH-1:0] nxt_period_eff;

    align_mode_t act_mode;
    align_mode_t stg_mode;
    align_mode_t src_mode;
    align_mode_t nxt_mode;

    channel_cfg_t in_cfg  [NUM_CHANNELS];
    channel_cfg_t act_cfg [NUM_CHANNELS];
    channel_cfg_t stg_cfg [NUM_CHANNELS];
    channel_cfg_t nxt_cfg [NUM_CHANNELS];

    // Unpack the per-channel inputs into config records.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            in_cfg[i].duty   = CFG_WIDTH'(pwm_duty_cycle[i*WIDTH +: WIDTH]);
            in_cfg[i].enable = channel_enable[i];
            in_cfg[i].invert = channel_invert[i];
`ifdef PWM_PHASE_OFFSET_EN
            in_cfg[i].phase  = CFG_WIDTH'(pwm_phase[i*WIDTH +: WIDTH]);
`else
            in_cfg[i].phase  = '0;
`endif
        end
    end

    // Next count and direction; boundary flags the edge that starts a period.
    always_comb begin
        period_eff   = (act_period == '0) ? WIDTH'(1) : act_period;
        cnt_nxt      = cnt;
        cnt_down_nxt = cnt_down;
        boundary     = 1'b0;
        if (act_mode == ALIGN_EDGE) begin
            cnt_down_nxt = 1'b0;
            if (cnt >= period_eff - WIDTH'(1)) begin
                cnt_nxt  = '0;
                boundary = 1'b1;
            end else begin
                cnt_nxt = cnt + WIDTH'(1);
            end
        end else if (!cnt_down) begin
            if (cnt >= period_eff - WIDTH'(1)) begin
                cnt_down_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + WIDTH'(1);
            end
        end else begin
            if (cnt == '0) begin
                cnt_down_nxt = 1'b0;
                boundary     = 1'b1;
            end else begin
                cnt_nxt = cnt - WIDTH'(1);
            end
        end
    end

    // Select what becomes active on the next edge; a same-edge strobe bypasses staging.
    always_comb begin
        load           = boundary && (update_pending || update_parameters);
        src_period     = update_parameters ? pwm_period : stg_period;
        src_mode       = update_parameters ? align_mode : stg_mode;
        nxt_period     = load ? src_period : act_period;
        nxt_mode       = load ? src_mode : act_mode;
        nxt_period_eff = (nxt_period == '0) ? WIDTH'(1) : nxt_period;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            nxt_cfg[i] = act_cfg[i];
            if (load) begin
                nxt_cfg[i] = update_parameters ? in_cfg[i] : stg_cfg[i];
            end
        end
    end

    // Counter, active settings and the period_start pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            cnt_down     <= 1'b0;
            act_period   <= DEFAULT_PERIOD;
            act_mode     <= ALIGN_EDGE;
            period_start <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                act_cfg[i] <= '0;
            end
        end else begin
            cnt          <= cnt_nxt;
            cnt_down     <= cnt_down_nxt;
            act_period   <= nxt_period;
            act_mode     <= nxt_mode;
            period_start <= boundary;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                act_cfg[i] <= nxt_cfg[i];
            end
        end
    end

    // Staging registers and the pending flag. The latest strobe wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_period     <= '0;
            stg_mode       <= ALIGN_EDGE;
            update_pending <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                stg_cfg[i] <= '0;
            end
        end else begin
            if (update_parameters) begin
                stg_period <= pwm_period;
                stg_mode   <= align_mode;
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    stg_cfg[i] <= in_cfg[i];
                end
            end
            if (load) begin
                update_pending <= 1'b0;
            end else if (update_parameters) begin
                update_pending <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        pwm_compare_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .cnt        (cnt_nxt),
            .period     (nxt_period_eff),
            .align_mode (nxt_mode),
            .cfg        (nxt_cfg[i]),
            .pwm        (pwm[i])
        );
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: directed, self-checking bench for pwm_multichannel.
// The phase-offset steps are compiled only when PWM_PHASE_OFFSET_EN is defined.
module tb_pwm_multichannel;
    import pwm_pkg::*;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk               = 1'b0;
    logic           reset_n           = 1'b0;
    logic           update_parameters = 1'b0;
    logic [W-1:0]   pwm_period        = '0;
    align_mode_t    align_mode        = ALIGN_EDGE;
    logic [N*W-1:0] pwm_duty_cycle    = '0;
    logic [N-1:0]   channel_enable    = '0;
    logic [N-1:0]   channel_invert    = '0;
`ifdef PWM_PHASE_OFFSET_EN
    logic [N*W-1:0] pwm_phase         = '0;
`endif
    logic [N-1:0]   pwm;
    logic           period_start;
    logic           update_pending;

    int n_cmp = 0;
    int n_err = 0;

    pwm_multichannel #(
        .WIDTH(W),
        .NUM_CHANNELS(N)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .update_parameters (update_parameters),
        .pwm_period        (pwm_period),
        .align_mode        (align_mode),
        .pwm_duty_cycle    (pwm_duty_cycle),
        .channel_enable    (channel_enable),
        .channel_invert    (channel_invert),
`ifdef PWM_PHASE_OFFSET_EN
        .pwm_phase         (pwm_phase),
`endif
        .pwm               (pwm),
        .period_start      (period_start),
        .update_pending    (update_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input int duty, input logic en, input logic inv);
        pwm_duty_cycle[ch*W +: W] = W'(duty);
        channel_enable[ch]        = en;
        channel_invert[ch]        = inv;
    endtask

    task automatic strobe();
        update_parameters = 1'b1;
        tick();
        update_parameters = 1'b0;
    endtask

    task automatic wait_ps();
        int b = 0;
        while (!period_start && b < 1000) begin
            tick();
            b++;
        end
        chk("ps_seen", 32'(period_start), 1);
    endtask

    task automatic measure(input int ch, input int n, output int hi, output int ps);
        hi = 0;
        ps = 0;
        for (int i = 0; i < n; i++) begin
            hi += int'(pwm[ch]);
            ps += int'(period_start);
            tick();
        end
    endtask

    task automatic gap(output int g, output int hi, output int pend);
        g    = 0;
        hi   = 0;
        pend = 0;
        do begin
            tick();
            g++;
            hi   += int'(pwm != '0);
            pend += int'(update_pending);
        end while (!period_start && g < 1000);
    endtask

    initial begin
        int hi, ps, g, pend, c, r;

        // Reset defaults
        repeat (3) tick();
        chk("rst_pwm", 32'(pwm), 0);
        chk("rst_ps", 32'(period_start), 0);
        chk("rst_pend", 32'(update_pending), 0);
        reset_n = 1'b1;
        gap(g, hi, pend);
        chk("dflt_first_gap", g, 255);
        chk("dflt_first_hi", hi, 0);
        gap(g, hi, pend);
        chk("dflt_gap", g, 255);
        chk("dflt_hi", hi, 0);
        chk("dflt_pend", pend, 0);

        // EDGE sweep, P=63
        pwm_period = 8'd63;
        align_mode = ALIGN_EDGE;
        for (int d = 1; d <= 63; d++) begin
            set_ch(0, d, 1'b1, 1'b0);
            strobe();
            wait_ps();
            if (d == 1) begin
                chk("edge_rise_with_ps", 32'(pwm[0]), 1);
            end
            measure(0, 4 * 63, hi, ps);
            chk("sweep_hi", hi, 4 * d);
            chk("sweep_ps", ps, 4);
        end
        set_ch(0, 0, 1'b1, 1'b0);
        strobe();
        wait_ps();
        measure(0, 4 * 63, hi, ps);
        chk("duty0_hi", hi, 0);
        chk("duty0_ps", ps, 4);
        set_ch(0, 70, 1'b1, 1'b0);
        strobe();
        wait_ps();
        measure(0, 4 * 63, hi, ps);
        chk("duty70_hi", hi, 252);
        measure(1, 63, hi, ps);
        chk("idle_ch1_hi", hi, 0);

        // CENTER, P=10, duty 3
        pwm_period = 8'd10;
        align_mode = ALIGN_CENTER;
        set_ch(0, 3, 1'b1, 1'b0);
        strobe();
        wait_ps();
        for (int i = 0; i < 20; i++) begin
            chk("ctr_pwm", 32'(pwm[0]), 32'(i <= 2 || i >= 17));
            chk("ctr_ps", 32'(period_start), 32'(i == 0));
            tick();
        end
        chk("ctr_ps_20", 32'(period_start), 1);

        // Update boundary, EDGE P=16
        pwm_period = 8'd16;
        align_mode = ALIGN_EDGE;
        set_ch(0, 4, 1'b1, 1'b0);
        strobe();
        wait_ps();
        r = int'($urandom_range(2, 10));
        c = 0;
        repeat (r) begin
            tick();
            c++;
        end
        set_ch(0, 12, 1'b1, 1'b0);
        strobe();
        c++;
        while (!period_start && c < 100) begin
            chk("mid_pend", 32'(update_pending), 1);
            chk("mid_old_duty", 32'(pwm[0]), 32'(c < 4));
            tick();
            c++;
        end
        chk("mid_len", c, 16);
        chk("mid_pend_clr", 32'(update_pending), 0);
        measure(0, 16, hi, ps);
        chk("mid_new_hi", hi, 12);

        // Strobe in the last cycle of the period
        repeat (15) tick();
        set_ch(0, 2, 1'b1, 1'b0);
        strobe();
        chk("last_ps", 32'(period_start), 1);
        chk("last_pend", 32'(update_pending), 0);
        measure(0, 16, hi, ps);
        chk("last_hi", hi, 2);

        // Two strobes in one period
        repeat (3) tick();
        set_ch(0, 9, 1'b1, 1'b0);
        strobe();
        repeat (2) tick();
        set_ch(0, 5, 1'b1, 1'b0);
        strobe();
        wait_ps();
        measure(0, 16, hi, ps);
        chk("two_strobe_hi", hi, 5);

        // Enable / invert
        set_ch(2, 4, 1'b0, 1'b1);
        strobe();
        wait_ps();
        measure(2, 16, hi, ps);
        chk("inv_dis_hi", hi, 16);
        set_ch(2, 4, 1'b1, 1'b1);
        strobe();
        wait_ps();
        chk("inv_en_first", 32'(pwm[2]), 0);
        measure(2, 16, hi, ps);
        chk("inv_en_hi", hi, 12);
        measure(3, 16, hi, ps);
        chk("dis_ch3_hi", hi, 0);

`ifdef PWM_PHASE_OFFSET_EN
        // Phase offsets, P=16, duty 8
        set_ch(0, 8, 1'b1, 1'b0);
        set_ch(1, 8, 1'b1, 1'b0);
        pwm_phase[0*W +: W] = 8'd0;
        pwm_phase[1*W +: W] = 8'd4;
        strobe();
        wait_ps();
        for (int i = 0; i < 16; i++) begin
            chk("ph_ch0", 32'(pwm[0]), 32'(i < 8));
            chk("ph_ch1_lead", 32'(pwm[1]), 32'(((i + 4) % 16) < 8));
            tick();
        end
        pwm_phase[1*W +: W] = 8'd20;
        strobe();
        wait_ps();
        for (int i = 0; i < 16; i++) begin
            chk("ph20_ch1", 32'(pwm[1]), 32'(i < 8));
            tick();
        end
        wait_ps();
`endif

        // Reset mid-period with an update pending
        repeat (6) tick();
        chk("pre_rst_pwm2", 32'(pwm[2]), 1);
        set_ch(2, 10, 1'b1, 1'b0);
        strobe();
        chk("pre_rst_pend", 32'(update_pending), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_pwm", 32'(pwm), 0);
        chk("mid_rst_pend", 32'(update_pending), 0);
        chk("mid_rst_ps", 32'(period_start), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        gap(g, hi, pend);
        chk("post_rst_gap", g, 255);
        chk("post_rst_hi", hi, 0);
        chk("post_rst_pend", pend, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
